// File: rtl/demux_router.sv
// Routes a byte stream to one of three decryptors through a small FIFO, ending each message on TOKEN.
// Optional feature: define DEMUX_DROP_CNT_EN to add a saturating 8-bit dropped-byte counter (drop_cnt_o).
module demux_router #(
  parameter int                 D_WIDTH = 8,
  parameter logic [D_WIDTH-1:0] TOKEN   = D_WIDTH'(8'hFA),
  parameter int                 DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         select,
  input  logic [D_WIDTH-1:0] data_i,
  input  logic               valid_i,
  input  logic               busy0_i,
  input  logic               busy1_i,
  input  logic               busy2_i,
  output logic [D_WIDTH-1:0] data0_o,
  output logic [D_WIDTH-1:0] data1_o,
  output logic [D_WIDTH-1:0] data2_o,
  output logic               valid0_o,
  output logic               valid1_o,
  output logic               valid2_o,
  output logic               ovf_o
`ifdef DEMUX_DROP_CNT_EN
  ,
  output logic [7:0]         drop_cnt_o
`endif
);

  // state | meaning
  // IDLE  | waiting for the first byte of a message; select is sampled here
  // ROUTE | message in progress, bytes pushed toward the latched channel
  // DRAIN | TOKEN queued, further input dropped until TOKEN leaves the FIFO
  typedef enum logic [1:0] {IDLE, ROUTE, DRAIN} state_t;

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  state_t             state;
  logic [1:0]         sel_q;
  logic [D_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      count;

  logic               busy_sel;
  logic               do_pop;
  logic               full;
  logic               accept;
  logic               drop;
  logic [D_WIDTH-1:0] head;

  always_comb begin
    busy_sel = 1'b1;
    case (sel_q)
      2'b00:   busy_sel = busy0_i;
      2'b01:   busy_sel = busy1_i;
      2'b10:   busy_sel = busy2_i;
      default: busy_sel = 1'b1;
    endcase
    head   = mem[rd_ptr];
    do_pop = (count != '0) && !busy_sel;
    full   = (count == CW'(DEPTH));
    accept = 1'b0;
    drop   = 1'b0;
    if (valid_i) begin
      case (state)
        IDLE:    accept = (select != 2'b11);
        ROUTE:   accept = !(full && !do_pop);
        default: accept = 1'b0;
      endcase
      drop = !accept;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= data_i;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state    <= IDLE;
      sel_q    <= 2'b00;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      data0_o  <= '0;
      data1_o  <= '0;
      data2_o  <= '0;
      valid0_o <= 1'b0;
      valid1_o <= 1'b0;
      valid2_o <= 1'b0;
      ovf_o    <= 1'b0;
    end else begin
      data0_o  <= '0;
      data1_o  <= '0;
      data2_o  <= '0;
      valid0_o <= 1'b0;
      valid1_o <= 1'b0;
      valid2_o <= 1'b0;
      ovf_o    <= drop;

      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        case (sel_q)
          2'b00: begin data0_o <= head; valid0_o <= 1'b1; end
          2'b01: begin data1_o <= head; valid1_o <= 1'b1; end
          2'b10: begin data2_o <= head; valid2_o <= 1'b1; end
          default: ;
        endcase
      end
      if (accept) wr_ptr <= wr_ptr + AW'(1);

      case ({accept, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase

      case (state)
        IDLE: if (accept) begin
          sel_q <= select;
          state <= ROUTE;
        end
        ROUTE: begin
          if (accept && data_i == TOKEN)     state <= DRAIN;
          else if (do_pop && head == TOKEN)  state <= IDLE;
        end
        DRAIN: if (do_pop && head == TOKEN) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DEMUX_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (rst_n)                          drop_cnt_o <= 8'd0;
    else if (drop && drop_cnt_o != 8'hFF) drop_cnt_o <= drop_cnt_o + 8'd1;
  end
`endif

endmodule

// File: tb/tb_demux_router.sv
// Scoreboard bench for demux_router: queue-based message model predicts outputs and drop pulses per edge.
module tb_demux_router;
  localparam int         DEPTH = 4;
  localparam logic [7:0] TOKEN = 8'hFA;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] select = 2'b00;
  logic [7:0] data_i = 8'h00;
  logic       valid_i = 1'b0;
  logic       busy0_i = 1'b0, busy1_i = 1'b0, busy2_i = 1'b0;
  logic [7:0] data0_o, data1_o, data2_o;
  logic       valid0_o, valid1_o, valid2_o, ovf_o;
`ifdef DEMUX_DROP_CNT_EN
  logic [7:0] drop_cnt_o;
`endif

  demux_router #(.D_WIDTH(8), .TOKEN(TOKEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .select(select), .data_i(data_i), .valid_i(valid_i),
    .busy0_i(busy0_i), .busy1_i(busy1_i), .busy2_i(busy2_i),
    .data0_o(data0_o), .data1_o(data1_o), .data2_o(data2_o),
    .valid0_o(valid0_o), .valid1_o(valid1_o), .valid2_o(valid2_o),
    .ovf_o(ovf_o)
`ifdef DEMUX_DROP_CNT_EN
    , .drop_cnt_o(drop_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {int cyc; int ch; logic [7:0] d;} exp_t;
  exp_t exp_q[$];
  int   ovf_q[$];
  int   obs_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   edge_n = 0;

  // Reference model: message mode, latched channel and the FIFO as a plain queue.
  typedef enum int {M_IDLE, M_ROUTE, M_DRAIN} mmode_t;
  mmode_t     m_mode = M_IDLE;
  int         m_sel = 0;
  logic [7:0] m_q[$];
  int         m_drops = 0;
  logic [2:0] m_busy;
  bit         m_pop, m_full, m_acc;
  logic [7:0] m_h;

  always @(posedge clk) begin
    edge_n++;
    if (rst_n) begin
      m_q.delete();
      m_mode = M_IDLE;
      m_sel = 0;
      m_drops = 0;
    end else begin
      m_busy = {busy2_i, busy1_i, busy0_i};
      m_pop  = (m_q.size() > 0) && !m_busy[m_sel];
      m_full = (m_q.size() == DEPTH);
      m_acc  = 0;
      m_h    = 8'h00;
      if (valid_i) begin
        if (m_mode == M_IDLE && select != 2'b11) m_acc = 1;
        else if (m_mode == M_ROUTE && !(m_full && !m_pop)) m_acc = 1;
        if (!m_acc) begin
          ovf_q.push_back(edge_n);
          if (m_drops < 255) m_drops++;
        end
      end
      if (m_pop) begin
        m_h = m_q.pop_front();
        exp_q.push_back('{edge_n, m_sel, m_h});
      end
      if (m_acc) m_q.push_back(data_i);
      case (m_mode)
        M_IDLE: if (m_acc) begin m_sel = int'(select); m_mode = M_ROUTE; end
        M_ROUTE: begin
          if (m_acc && data_i == TOKEN) m_mode = M_DRAIN;
          else if (m_pop && m_h == TOKEN) m_mode = M_IDLE;
        end
        default: if (m_pop && m_h == TOKEN) m_mode = M_IDLE;
      endcase
    end
  end

  // Monitor: compares whatever the DUT presents against the scoreboard queues.
  always @(negedge clk) begin
    int nval, ch;
    logic [7:0] d;
    exp_t x;
    nval = int'(valid0_o) + int'(valid1_o) + int'(valid2_o);
    if (edge_n > 0) begin
      vectors++;
      if (nval > 1 || (!valid0_o && data0_o != 0) || (!valid1_o && data1_o != 0) ||
          (!valid2_o && data2_o != 0)) begin
        miscompares++;
        $display("FAIL quiet_channels edge %0d: valid=%b%b%b data=%h/%h/%h, required one valid max and idle data 0",
                 edge_n, valid2_o, valid1_o, valid0_o, data2_o, data1_o, data0_o);
      end
      if (nval == 1) begin
        ch = valid0_o ? 0 : (valid1_o ? 1 : 2);
        d  = valid0_o ? data0_o : (valid1_o ? data1_o : data2_o);
        obs_q.push_back(ch * 256 + int'(d));
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_output edge %0d: ch%0d=%h, required no output", edge_n, ch, d);
        end else begin
          x = exp_q.pop_front();
          if (x.cyc != edge_n || x.ch != ch || x.d !== d) begin
            miscompares++;
            $display("FAIL output edge %0d: got ch%0d=%h, required ch%0d=%h at edge %0d",
                     edge_n, ch, d, x.ch, x.d, x.cyc);
          end
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= edge_n) begin
        x = exp_q.pop_front();
        vectors++;
        miscompares++;
        $display("FAIL missing_output edge %0d: got none, required ch%0d=%h", edge_n, x.ch, x.d);
      end
      if (ovf_o === 1'b1) begin
        vectors++;
        if (ovf_q.size() == 0 || ovf_q[0] != edge_n) begin
          miscompares++;
          $display("FAIL ovf edge %0d: got pulse, required none", edge_n);
        end
        if (ovf_q.size() > 0 && ovf_q[0] <= edge_n) void'(ovf_q.pop_front());
      end else if (ovf_q.size() > 0 && ovf_q[0] <= edge_n) begin
        void'(ovf_q.pop_front());
        vectors++;
        miscompares++;
        $display("FAIL ovf edge %0d: got %b, required pulse", edge_n, ovf_o);
      end
    end
  end

  task automatic drv(input logic r, input logic v, input logic [1:0] s,
                     input logic [7:0] d, input logic [2:0] b);
    @(negedge clk);
    rst_n = r; valid_i = v; select = s; data_i = d;
    {busy2_i, busy1_i, busy0_i} = b;
  endtask

  task automatic idle(input int n, input logic [2:0] b);
    repeat (n) drv(1'b0, 1'b0, 2'b00, 8'h00, b);
  endtask

  task automatic check_obs(input string name, input int want[$]);
    vectors++;
    if (obs_q.size() != want.size()) begin
      miscompares++;
      $display("FAIL %s count: got %0d outputs, required %0d", name, obs_q.size(), want.size());
    end else begin
      foreach (want[i]) if (obs_q[i] != want[i]) begin
        miscompares++;
        $display("FAIL %s item %0d: got %h, required %h", name, i, obs_q[i], want[i]);
      end
    end
  endtask

  initial begin
    logic [7:0] outs [7];
    drv(1'b1, 1'b0, 2'b00, 8'h00, 3'b000);
    drv(1'b0, 1'b0, 2'b00, 8'h00, 3'b000);
    outs = '{data0_o, data1_o, data2_o, 8'(valid0_o), 8'(valid1_o), 8'(valid2_o), 8'(ovf_o)};
    foreach (outs[i]) begin
      vectors++;
      if (outs[i] !== 8'h00) begin
        miscompares++;
        $display("FAIL reset_out%0d: got %h, required 00", i, outs[i]);
      end
    end

    // Channel 1 message, straight through.
    obs_q.delete();
    drv(0, 1, 2'b01, 8'h41, 3'b000);
    drv(0, 1, 2'b01, 8'h42, 3'b000);
    drv(0, 1, 2'b01, 8'hFA, 3'b000);
    idle(5, 3'b000);
    check_obs("ch1_msg", '{256 + 'h41, 256 + 'h42, 256 + 'hFA});

    // select change mid-message is ignored.
    obs_q.delete();
    drv(0, 1, 2'b10, 8'h55, 3'b000);
    drv(0, 1, 2'b00, 8'h66, 3'b000);
    drv(0, 1, 2'b00, 8'hFA, 3'b000);
    idle(5, 3'b000);
    check_obs("sel_held", '{512 + 'h55, 512 + 'h66, 512 + 'hFA});

    // Full FIFO drops TOKEN; contents drain once busy clears.
    obs_q.delete();
    for (int i = 1; i <= 4; i++) drv(0, 1, 2'b00, 8'(i), 3'b001);
    drv(0, 1, 2'b00, 8'hFA, 3'b001);
    idle(3, 3'b001);
    idle(6, 3'b000);
    drv(0, 1, 2'b00, 8'hFA, 3'b000);
    idle(4, 3'b000);
    check_obs("full_drop", '{1, 2, 3, 4, 'hFA});

    // Invalid select.
    obs_q.delete();
    drv(0, 1, 2'b11, 8'h33, 3'b000);
    idle(4, 3'b000);
    check_obs("sel11", '{});

    // Reset mid-message, then a fresh message on channel 2.
    obs_q.delete();
    drv(0, 1, 2'b00, 8'h10, 3'b001);
    drv(0, 1, 2'b00, 8'h11, 3'b001);
    drv(1, 0, 2'b00, 8'h00, 3'b001);
    drv(0, 1, 2'b10, 8'h77, 3'b001);
    drv(0, 1, 2'b10, 8'hFA, 3'b001);
    idle(5, 3'b000);
    check_obs("post_reset", '{512 + 'h77, 512 + 'hFA});

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] d;
      d = ($urandom_range(7) == 0) ? TOKEN : 8'($urandom);
      drv(($urandom_range(299) == 0), ($urandom_range(1) == 1), 2'($urandom),
          d, {($urandom_range(3) == 0), ($urandom_range(3) == 0), ($urandom_range(3) == 0)});
    end
    idle(30, 3'b000);

    vectors++;
    if (exp_q.size() != 0 || ovf_q.size() != 0) begin
      miscompares++;
      $display("FAIL leftover: got %0d outputs and %0d pulses pending, required 0",
               exp_q.size(), ovf_q.size());
    end
`ifdef DEMUX_DROP_CNT_EN
    vectors++;
    if (int'(drop_cnt_o) != m_drops) begin
      miscompares++;
      $display("FAIL drop_cnt: got %0d, required %0d", drop_cnt_o, m_drops);
    end
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
